// File: rtl/iter_shifter_pkg.sv
// rtl/iter_shifter_pkg.sv - shared types and constants for the iterative shifter
package iter_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// rtl/iter_shifter_shift_step.sv - one-position left/right shift with selectable fill bit
module shift_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic             left,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    if (left) begin
      result = {data[WIDTH-2:0], 1'b0};
    end else begin
      result = {fill, data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle SLL/SRL/SRA unit stepping one bit per clock
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_left,
  input  logic               in_arith,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]         state_q;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;
  logic               fill_q;
  logic [WIDTH-1:0]   step_data;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data   (data_q),
    .left   (dir_q),
    .fill   (fill_q),
    .result (step_data)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else if (flush) begin
      // flush beats any pending accept or handshake; data_q is left as garbage
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            cnt_q   <= in_shamt;
            dir_q   <= in_left;
            fill_q  <= in_arith & ~in_left & in_data[WIDTH-1];
            state_q <= (in_shamt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          data_q <= step_data;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - directed self-checking bench for iter_shifter
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_left;
  logic        in_arith;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  iter_shifter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_left   (in_left),
    .in_arith  (in_arith),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; all driving and sampling happen 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic l, input logic a);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_left  = l;
    in_arith = a;
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; also tracks busy staying high.
  task automatic wait_valid(output int n, output logic busy_ok);
    n = 0;
    busy_ok = busy;
    while (!out_valid && n < 100) begin
      step();
      n++;
      busy_ok = busy_ok & busy;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  int          n;
  logic        bok;
  logic        hold_ok;
  logic [31:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0;
    in_left = 1'b0; in_arith = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // SLL 1 << 4
    send(32'h0000_0001, 5'd4, 1'b1, 1'b0);
    wait_valid(n, bok);
    check("sll_latency", 32'(n), 32'd4);
    check("sll_busy", 32'(bok), 32'd1);
    check("sll_data", out_data, 32'h0000_0010);
    take();
    check("sll_idle", 32'(in_ready), 32'd1);

    // SRA / SRL by 31
    send(32'h8000_0000, 5'd31, 1'b0, 1'b1);
    wait_valid(n, bok);
    check("sra_latency", 32'(n), 32'd31);
    check("sra_data", out_data, 32'hFFFF_FFFF);
    take();
    send(32'h8000_0000, 5'd31, 1'b0, 1'b0);
    wait_valid(n, bok);
    check("srl_data", out_data, 32'h0000_0001);
    take();

    // zero shift
    send(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
    check("zero_valid", 32'(out_valid), 32'd1);
    check("zero_in_ready", 32'(in_ready), 32'd0);
    check("zero_data", out_data, 32'hDEAD_BEEF);
    take();

    // arith ignored on left shift
    send(32'h8000_0001, 5'd1, 1'b1, 1'b1);
    wait_valid(n, bok);
    check("sll_arith_latency", 32'(n), 32'd1);
    check("sll_arith_data", out_data, 32'h0000_0002);
    take();

    // backpressure with a competing request held on the input
    send(32'h0000_00F0, 5'd3, 1'b0, 1'b0);
    wait_valid(n, bok);
    held = out_data;
    check("bp_data", held, 32'h0000_001E);
    in_valid = 1'b1; in_data = 32'h5; in_shamt = 5'd0; in_left = 1'b1; in_arith = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      hold_ok = hold_ok & out_valid & ~in_ready & (out_data == held);
    end
    check("bp_hold", 32'(hold_ok), 32'd1);
    take();
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("b2b_accept", 32'(out_valid), 32'd1);
    check("b2b_data", out_data, 32'h0000_0005);
    take();

    // flush mid-shift
    send(32'h0000_FFFF, 5'd10, 1'b1, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ready", 32'(in_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    hold_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      hold_ok = hold_ok & ~out_valid;
    end
    check("flush_no_valid", 32'(hold_ok), 32'd1);
    send(32'h0000_0003, 5'd1, 1'b0, 1'b0);
    wait_valid(n, bok);
    check("post_flush_latency", 32'(n), 32'd1);
    check("post_flush_data", out_data, 32'h0000_0001);
    take();

    // flush in IDLE blocks a simultaneous request
    flush = 1'b1; in_valid = 1'b1; in_shamt = 5'd0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("idle_flush_busy", 32'(busy), 32'd0);

    // async reset between edges
    send(32'h0000_1234, 5'd20, 1'b1, 1'b0);
    step(); step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_ready", 32'(in_ready), 32'd1);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_data", out_data, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    send(32'h0000_0001, 5'd2, 1'b1, 1'b0);
    wait_valid(n, bok);
    check("post_reset_latency", 32'(n), 32'd2);
    check("post_reset_data", out_data, 32'h0000_0004);
    take();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
